// File: rtl/or_gate_pkg.sv
// or_gate_pkg: shared constants, types and helpers for the or_gate block
// and its output FIFO (or_gate_skid).
package or_gate_pkg;

  // Default operand/result width of the OR datapath.
  localparam int WIDTH_DEFAULT = 1;

  // Number of result entries held between acceptance and consumption.
  localparam int FIFO_DEPTH = 2;

  // Occupancy counter must represent 0..FIFO_DEPTH inclusive.
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;

  // True while the FIFO can take another entry.
  function automatic logic has_room(input occ_t occ);
    return (occ < occ_t'(FIFO_DEPTH));
  endfunction

  // True while the FIFO holds at least one entry.
  function automatic logic not_empty(input occ_t occ);
    return (occ != occ_t'(0));
  endfunction

endpackage

// File: rtl/or_gate_skid.sv
// or_gate_skid: 2-entry result FIFO. Entry 0 is always the head, so the
// head is a plain register. Unused slots are held at zero, which makes the
// head read as zero whenever the FIFO is empty.
module or_gate_skid
  import or_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             ready,
  output logic             valid
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  occ_t             occ;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against occupancy so misuse can never corrupt the FIFO.
  always_comb begin
    do_push = push & has_room(occ);
    do_pop  = pop & not_empty(occ);
  end

  // Storage and occupancy update; reset empties the FIFO and zeroes slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= {WIDTH{1'b0}};
      slot1 <= {WIDTH{1'b0}};
      occ   <= occ_t'(0);
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == occ_t'(0)) begin
            slot0 <= din;
          end else begin
            slot1 <= din;
          end
          occ <= occ + occ_t'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= {WIDTH{1'b0}};
          occ   <= occ - occ_t'(1);
        end
        2'b11: begin
          // Occupancy stays the same; new data lands behind whatever remains.
          if (occ == occ_t'(1)) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
          occ <= occ;
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

  // Status decode straight from registered state.
  always_comb begin
    head  = slot0;
    ready = has_room(occ);
    valid = not_empty(occ);
  end

endmodule

// File: rtl/or_gate.sv
// or_gate: combinational bitwise OR (F_o, any_o) plus a valid/ready
// registered result path buffered by a 2-entry FIFO (or_gate_skid).
// Optional accumulator enabled by defining OR_GATE_ACC_EN, which also adds
// the acc_clr_i port.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic [WIDTH-1:0] F_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] Q_o,
  output logic             any_o
`ifdef OR_GATE_ACC_EN
  ,
  input  logic             acc_clr_i
`endif
);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stored;
  logic             fifo_ready;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_head;

  // Pure combinational OR path; never touched by clock or reset.
  always_comb begin
    F_o   = A_i | B_i;
    any_o = |F_o;
  end

  // Handshake decode.
  always_comb begin
    push        = in_valid_i & fifo_ready;
    pop         = fifo_valid & out_ready_i;
    in_ready_o  = fifo_ready;
    out_valid_o = fifo_valid;
    Q_o         = fifo_head;
  end

`ifdef OR_GATE_ACC_EN
  logic [WIDTH-1:0] acc;

  // A clear drops the old accumulator before this cycle's beat is merged.
  always_comb begin
    if (acc_clr_i) begin
      stored = F_o;
    end else begin
      stored = F_o | acc;
    end
  end

  // Accumulator follows each stored value; clear without a beat zeroes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc <= {WIDTH{1'b0}};
    end else if (push) begin
      acc <= stored;
    end else if (acc_clr_i) begin
      acc <= {WIDTH{1'b0}};
    end else begin
      acc <= acc;
    end
  end
`else
  // Without the accumulator the stored value is the plain OR result.
  always_comb begin
    stored = F_o;
  end
`endif

  or_gate_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .pop  (pop),
    .din  (stored),
    .head (fifo_head),
    .ready(fifo_ready),
    .valid(fifo_valid)
  );

endmodule

// File: tb/tb_or_gate.sv
// tb_or_gate: self-checking bench for or_gate (WIDTH=4). A reference
// queue holds expected results as beats are offered and is compared
// against Q_o as the DUT presents them.
module tb_or_gate;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] f;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         any;
`ifdef OR_GATE_ACC_EN
  logic         acc_clr;
`endif

  int total  = 0;
  int passed = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] acc_m;

  always #5 clk = ~clk;

  or_gate #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .A_i        (a),
    .B_i        (b),
    .F_o        (f),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .Q_o        (q),
    .any_o      (any)
`ifdef OR_GATE_ACC_EN
    ,
    .acc_clr_i  (acc_clr)
`endif
  );

  // Advance one clock, updating the reference model from the inputs
  // present at the edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    bit           do_pop;
    bit           do_push;
    logic [W-1:0] val;
    if (rst) begin
      sb.delete();
      acc_m = '0;
    end else begin
      do_pop  = (sb.size() > 0) && out_ready;
      do_push = in_valid && (sb.size() < 2);
      val     = a | b;
`ifdef OR_GATE_ACC_EN
      if (!acc_clr) val = val | acc_m;
      if (do_push) acc_m = val;
      else if (acc_clr) acc_m = '0;
`endif
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (q !== 4'b0000) $display("FAIL reset_q: got %h expected 0", q); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  task automatic test_comb();
    logic [W-1:0] exp_f;
    // Truth table 00,10,01,11 applied to every bit, 5 time units apart.
    for (int i = 0; i < 4; i++) begin
      a = {W{i[0]}};
      b = {W{i[1]}};
      exp_f = (i == 0) ? 4'b0000 : 4'b1111;
      #5;
      total++; if (f !== exp_f) $display("FAIL comb_f_tt%0d: got %h expected %h", i, f, exp_f); else passed++;
      total++; if (any !== (i != 0)) $display("FAIL comb_any_tt%0d: got %b expected %b", i, any, (i != 0)); else passed++;
    end
    // Mixed per-bit patterns with reset held high: output must not care.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom);
      b = (i == 0) ? 4'b0000 : 4'($urandom);
      if (i == 0) a = 4'b0000;
      exp_f = a | b;
      #5;
      total++; if (f !== exp_f) $display("FAIL comb_f_rst%0d: got %h expected %h", i, f, exp_f); else passed++;
      total++; if (any !== (a != 4'b0000 || b != 4'b0000)) $display("FAIL comb_any_rst%0d: got %b", i, any); else passed++;
    end
    a = 4'b0011; b = 4'b0101; #5;
    total++; if (f !== 4'b0111) $display("FAIL comb_mixed: got %h expected 7", f); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'b0001; b = 4'b0000;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
    total++; if (q !== 4'b0001 || q !== sb[0]) $display("FAIL single_q: got %h expected 1", q); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL single_valid_after: got %b expected 0", out_valid); else passed++;
    total++; if (q !== 4'b0000) $display("FAIL single_q_after: got %h expected 0", q); else passed++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] beats[3] = '{4'b0011, 4'b0100, 4'b1000};
    logic [W-1:0] first;
    logic [W-1:0] exp_q;
    out_ready = 1'b0;
    b = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      total++; if (in_ready !== (k < 2)) $display("FAIL bp_in_ready%0d: got %b expected %b", k, in_ready, (k < 2)); else passed++;
      a = beats[k];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    first = sb[0];
    for (int k = 0; k < 2; k++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b1 || q !== first) $display("FAIL bp_stable: got %b/%h expected 1/%h", out_valid, q, first); else passed++;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q = (sb.size() > 0) ? sb[0] : 4'b0000;
      total++; if (out_valid !== (sb.size() > 0) || q !== exp_q) $display("FAIL bp_drain%0d: got %b/%h expected %b/%h", k, out_valid, q, (sb.size() > 0), exp_q); else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q;
    for (int k = 0; k < 40; k++) begin
      exp_q = (sb.size() > 0) ? sb[0] : 4'b0000;
      total++; if (out_valid !== (sb.size() > 0)) $display("FAIL b2b_valid%0d: got %b expected %b", k, out_valid, (sb.size() > 0)); else passed++;
      total++; if (q !== exp_q) $display("FAIL b2b_q%0d: got %h expected %h", k, q, exp_q); else passed++;
      total++; if (in_ready !== (sb.size() < 2)) $display("FAIL b2b_ready%0d: got %b expected %b", k, in_ready, (sb.size() < 2)); else passed++;
      a = 4'($urandom);
      b = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 4'b0110; b = 4'b0001; tick();
    a = 4'b1001; b = 4'b0000; tick();
    total++; if (in_ready !== 1'b0) $display("FAIL rmid_full: got %b expected 0", in_ready); else passed++;
    rst = 1'b1;
    a = 4'b1111;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", out_valid); else passed++;
    total++; if (q !== 4'b0000) $display("FAIL rmid_q: got %h expected 0", q); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_no_beat: got %b expected 0", out_valid); else passed++;
  endtask

`ifdef OR_GATE_ACC_EN
  task automatic test_acc();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'b0001; b = 4'b0000; tick();
    total++; if (q !== 4'b0001) $display("FAIL acc_beat1: got %h expected 1", q); else passed++;
    a = 4'b0000; b = 4'b0100; tick();
    total++; if (q !== 4'b0101) $display("FAIL acc_beat2: got %h expected 5", q); else passed++;
    acc_clr = 1'b1;
    a = 4'b1000; b = 4'b0000; tick();
    acc_clr = 1'b0;
    in_valid = 1'b0;
    total++; if (q !== 4'b1000) $display("FAIL acc_clr_beat: got %h expected 8", q); else passed++;
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    in_valid = 1'b1;
    a = 4'b0010; b = 4'b0000; tick();
    in_valid = 1'b0;
    total++; if (q !== 4'b0010) $display("FAIL acc_clr_idle: got %h expected 2", q); else passed++;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
    acc_m = '0;
`ifdef OR_GATE_ACC_EN
    acc_clr = 1'b0;
`endif
    test_reset();
    test_comb();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef OR_GATE_ACC_EN
    test_acc();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
